// File: rtl/gf180mcu_fd_sc_mcu9t5v0__arb4_ctrl_if.sv
// Request/grant bundle shared by the requesters and the arbiter.
// The master modport is the requester side; the slave modport is the arbiter.
interface gf180mcu_fd_sc_mcu9t5v0__arb4_ctrl_if #(
    parameter int unsigned N = 4
);
    localparam int unsigned W = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0] REQ;
    logic [N-1:0] GNT;
    logic         BUSY;
    logic [W-1:0] OWNER;
    logic         FORCED;

    modport master (output REQ, input GNT, input BUSY, input OWNER, input FORCED);
    modport slave  (input REQ, output GNT, output BUSY, output OWNER, output FORCED);
endinterface

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__arb4_ctrl.sv
// Round-robin arbiter with a bounded tenure per grant.
// A one-cycle zero-grant gap separates tenures; FORCED flags a timeout release.
module gf180mcu_fd_sc_mcu9t5v0__arb4_ctrl #(
    parameter int unsigned N       = 4,
    parameter int unsigned MAXHOLD = 8
) (
    input  logic                                    CLK,
    input  logic                                    RST,
    gf180mcu_fd_sc_mcu9t5v0__arb4_ctrl_if.slave     bus
);
    localparam int unsigned W  = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CW = 8;

    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

    state_t          r_state, w_state_nxt;
    logic [N-1:0]    r_gnt, w_gnt_nxt;
    logic            r_busy, w_busy_nxt;
    logic [W-1:0]    r_owner, w_owner_nxt;
    logic [W-1:0]    r_ptr, w_ptr_nxt;
    logic            r_forced, w_forced_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;
    logic [W-1:0]    w_winner;
    logic [W-1:0]    w_owner_inc;
    logic            w_any;
    logic            w_owner_req;

    // First set request at or above the pointer, wrapping past N-1.
    always_comb begin
        w_any    = 1'b0;
        w_winner = r_ptr;
        for (int unsigned i = 0; i < N; i++) begin
            if (!w_any && bus.REQ[W'((32'(r_ptr) + i) % N)]) begin
                w_any    = 1'b1;
                w_winner = W'((32'(r_ptr) + i) % N);
            end
        end
    end

    assign w_owner_req = bus.REQ[r_owner];
    assign w_owner_inc = (r_owner == W'(N - 1)) ? '0 : r_owner + W'(1);

    always_comb begin
        w_state_nxt  = r_state;
        w_gnt_nxt    = r_gnt;
        w_busy_nxt   = r_busy;
        w_owner_nxt  = r_owner;
        w_ptr_nxt    = r_ptr;
        w_forced_nxt = 1'b0;
        w_cnt_nxt    = r_cnt;
        case (r_state)
            IDLE, GAP: begin
                w_gnt_nxt  = '0;
                w_busy_nxt = 1'b0;
                w_cnt_nxt  = '0;
                w_state_nxt = IDLE;
                if (w_any) begin
                    w_state_nxt = GRANT;
                    w_gnt_nxt   = N'(1) << w_winner;
                    w_busy_nxt  = 1'b1;
                    w_owner_nxt = w_winner;
                    w_cnt_nxt   = CW'(1);
                end
            end
            GRANT: begin
                // Voluntary release wins over a coincident timeout.
                if (!w_owner_req || (r_cnt >= CW'(MAXHOLD))) begin
                    w_state_nxt  = GAP;
                    w_gnt_nxt    = '0;
                    w_busy_nxt   = 1'b0;
                    w_ptr_nxt    = w_owner_inc;
                    w_cnt_nxt    = '0;
                    w_forced_nxt = w_owner_req;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = '0;
                w_busy_nxt  = 1'b0;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= IDLE;
            r_gnt    <= '0;
            r_busy   <= 1'b0;
            r_owner  <= '0;
            r_ptr    <= '0;
            r_forced <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_gnt    <= w_gnt_nxt;
            r_busy   <= w_busy_nxt;
            r_owner  <= w_owner_nxt;
            r_ptr    <= w_ptr_nxt;
            r_forced <= w_forced_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

    assign bus.GNT    = r_gnt;
    assign bus.BUSY   = r_busy;
    assign bus.OWNER  = r_owner;
    assign bus.FORCED = r_forced;
endmodule
